// File: rtl/mod_arb_pkg.sv
// Shared defaults and the requester-index width helper for the modular add arbiter.
package mod_arb_pkg;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_NUM_REQ    = 4;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mod_add_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping, as one-hot plus index.
module mod_add_rr_pick
  import mod_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  // Rotating priority search starting at ptr.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = {NUM_REQ{1'b0}};
    winner    = {ID_W{1'b0}};
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        winner     = ID_W'(idx);
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/mod_add_arb.sv
// Round-robin arbitrated modular adder with a single registered response stage.
// Optional feature: define MOD_ADD_ARB_SUB_EN to add per-requester modular subtract (req_sub).
module mod_add_arb
  import mod_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opB,
`ifdef MOD_ADD_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]            req_sub,
`endif
  input  logic [DATA_WIDTH-1:0]         opM,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id
);

  logic                  free_s;
  logic                  fire_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [ID_W-1:0]       winner_s;
  logic                  any_s;
  logic [ID_W-1:0]       ptr_r;
  logic [ID_W-1:0]       ptr_next_s;
  logic [DATA_WIDTH-1:0] op_a_s;
  logic [DATA_WIDTH-1:0] op_b_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH:0]   mod_ext_s;
  logic [DATA_WIDTH-1:0] add_res_s;
  logic [DATA_WIDTH-1:0] result_s;

  mod_add_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .winner    (winner_s),
    .any_valid (any_s)
  );

  assign free_s = !rsp_valid || rsp_ready;
  assign fire_s = free_s && any_s && !rst;

  // Grant is only offered when the output register can take the result.
  always_comb begin
    if (free_s && !rst) begin
      req_ready = grant_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Winner operands and pointer advance.
  always_comb begin
    op_a_s = req_opA[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];
    op_b_s = req_opB[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];
    if (winner_s == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = {ID_W{1'b0}};
    end else begin
      ptr_next_s = winner_s + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Modular add: the extra sum bit keeps the carry-out visible to the compare.
  always_comb begin
    sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
    mod_ext_s = {1'b0, opM};
    if (sum_s >= mod_ext_s) begin
      add_res_s = DATA_WIDTH'(sum_s - mod_ext_s);
    end else begin
      add_res_s = DATA_WIDTH'(sum_s);
    end
  end

`ifdef MOD_ADD_ARB_SUB_EN
  logic [DATA_WIDTH-1:0] diff_s;
  logic [DATA_WIDTH-1:0] sub_res_s;

  // Modular subtract: a wrapped difference plus M lands back in range.
  always_comb begin
    diff_s = op_a_s - op_b_s;
    if (op_a_s >= op_b_s) begin
      sub_res_s = diff_s;
    end else begin
      sub_res_s = diff_s + opM;
    end
    if (req_sub[winner_s]) begin
      result_s = sub_res_s;
    end else begin
      result_s = add_res_s;
    end
  end
`else
  assign result_s = add_res_s;
`endif

  // Response register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= {DATA_WIDTH{1'b0}};
      rsp_id    <= {ID_W{1'b0}};
      ptr_r     <= {ID_W{1'b0}};
    end else if (fire_s) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result_s;
      rsp_id    <= winner_s;
      ptr_r     <= ptr_next_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_mod_add_arb.sv
// Directed bench for mod_add_arb with a per-cycle reference model and literal spot checks.
// Define MOD_ADD_ARB_SUB_EN to also exercise the modular subtract option.
module tb_mod_add_arb;

  localparam int DW = 256;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_opA;
  logic [NR*DW-1:0] req_opB;
`ifdef MOD_ADD_ARB_SUB_EN
  logic [NR-1:0]    req_sub;
`endif
  logic [DW-1:0]    opM;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic [IW-1:0]    rsp_id;

  int n_checks;
  int n_errors;

  // Reference model state: what the response register and pointer must hold.
  int            m_ptr;
  logic          m_vld;
  logic [DW-1:0] m_data;
  int            m_id;

  mod_add_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opA   (req_opA),
    .req_opB   (req_opB),
`ifdef MOD_ADD_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .opM       (opM),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mod_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] m, input logic sub);
    logic [DW+1:0] wide;
    logic [DW-1:0] res;
    if (sub) begin
      if (a >= b) wide = {2'b00, a} - {2'b00, b};
      else        wide = {2'b00, a} + {2'b00, m} - {2'b00, b};
    end else begin
      wide = {2'b00, a} + {2'b00, b};
      if (wide >= {2'b00, m}) wide = wide - {2'b00, m};
    end
    res = wide[DW-1:0];
    return res;
  endfunction

  function automatic logic sub_of(input int i);
`ifdef MOD_ADD_ARB_SUB_EN
    return req_sub[i];
`else
    return (i < 0);
`endif
  endfunction

  // One cycle: inputs already set; compare against model, advance model, cross the rising edge.
  task automatic step();
    int win;
    int idx;
    logic [NR-1:0] exp_rdy;
    #1;
    win = -1;
    exp_rdy = '0;
    if (!rst && (!m_vld || rsp_ready)) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    chk("rsp_valid", DW'(rsp_valid), DW'(m_vld));
    if (m_vld) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id", DW'(rsp_id), DW'(m_id));
    end
    if (rst) begin
      m_vld = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
    end else if (win >= 0) begin
      m_vld  = 1'b1;
      m_data = mod_op(req_opA[win*DW +: DW], req_opB[win*DW +: DW], opM, sub_of(win));
      m_id   = win;
      m_ptr  = (win + 1) % NR;
    end else if (rsp_ready) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_opA[i*DW +: DW] = a;
    req_opB[i*DW +: DW] = b;
  endtask

  task automatic expect_rsp(input string name, input logic [DW-1:0] data, input int id);
    chk({name, "_valid"}, DW'(rsp_valid), DW'(1'b1));
    chk({name, "_data"}, rsp_data, data);
    chk({name, "_id"}, DW'(rsp_id), DW'(id));
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
  endtask

  initial begin
    logic [DW-1:0] big_m;
    logic [DW-1:0] half;
    logic [NR-1:0] vpat [16];
    logic [15:0]   rpat;
    n_checks = 0;
    n_errors = 0;
    m_ptr = 0; m_vld = 1'b0; m_data = '0; m_id = 0;
    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_opA = '0;
    req_opB = '0;
    opM = DW'(97);
`ifdef MOD_ADD_ARB_SUB_EN
    req_sub = 4'h0;
`endif
    @(negedge clk);

    // Reset held two cycles with every requester valid.
    step();
    step();
    chk("reset_ready", DW'(req_ready), DW'(4'h0));
    chk("reset_valid", DW'(rsp_valid), DW'(1'b0));
    chk("reset_data", rsp_data, DW'(0));
    chk("reset_id", DW'(rsp_id), DW'(0));

    // Single adds on requester 2.
    rst = 1'b0;
    req_valid = 4'b0100;
    set_op(2, DW'(60), DW'(50));
    step();
    expect_rsp("add_wrap", DW'(13), 2);
    set_op(2, DW'(10), DW'(20));
    step();
    expect_rsp("add_plain", DW'(30), 2);
    drain();
    chk("clear_valid", DW'(rsp_valid), DW'(1'b0));

    // Bring the pointer to 0, then run all four continuously.
    for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), DW'(10 * i));
    req_valid = 4'b1000;
    step();
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_rsp("rr", DW'(i % NR + 1 + 10 * (i % NR)), i % NR);
    end

    // Backpressure: response frozen, nothing granted, then immediate regrant.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_rsp("bp_hold", DW'(1), 0);
      chk("bp_ready", DW'(req_ready), DW'(4'h0));
    end
    rsp_ready = 1'b1;
    step();
    expect_rsp("bp_release", DW'(12), 1);
    drain();

    // Boundary arithmetic on requester 0.
    big_m = '1;
    opM = big_m;
    req_valid = 4'b0001;
    set_op(0, big_m - DW'(1), big_m - DW'(1));
    step();
    expect_rsp("max_mod", big_m - DW'(2), 0);
    set_op(0, DW'(1), big_m - DW'(1));
    step();
    expect_rsp("sum_eq_m", DW'(0), 0);
    drain();
    half = '0;
    half[DW-1] = 1'b1;
    opM = big_m - DW'(188);
    req_valid = 4'b0001;
    set_op(0, half, half);
    step();
    expect_rsp("carry_out", DW'(189), 0);
    drain();

    // Mixed valid/ready pattern checked only by the model.
    opM = DW'(97);
    for (int i = 0; i < NR; i++) set_op(i, DW'((13 * i + 40) % 97), DW'((29 * i + 70) % 97));
    vpat = '{4'h5, 4'hA, 4'h0, 4'h3, 4'hC, 4'h9, 4'h6, 4'hF,
             4'h1, 4'h2, 4'h4, 4'h8, 4'hE, 4'h7, 4'hB, 4'hD};
    rpat = 16'b1011_0110_1110_0101;
    for (int i = 0; i < 16; i++) begin
      req_valid = vpat[i];
      rsp_ready = rpat[i];
      step();
    end
    drain();
    drain();

`ifdef MOD_ADD_ARB_SUB_EN
    // Modular subtract.
    req_valid = 4'b0010;
    req_sub = 4'b0010;
    set_op(1, DW'(10), DW'(20));
    step();
    expect_rsp("sub_wrap", DW'(87), 1);
    set_op(1, DW'(20), DW'(10));
    step();
    expect_rsp("sub_plain", DW'(10), 1);
    drain();
    req_sub = 4'b0000;
`endif

    // Reset discards a held response.
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    set_op(0, DW'(5), DW'(6));
    step();
    rst = 1'b1;
    step();
    chk("rst_discard_valid", DW'(rsp_valid), DW'(1'b0));
    chk("rst_discard_ready", DW'(req_ready), DW'(4'h0));
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
